// File: rtl/mem_stage_pipe.sv
// Memory stage: local data memory with fixed wait-state access and MEM/WB register.
// Optional MEM_STAGE_STATS_EN adds load/store/stall event counters.
module mem_stage_pipe #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 4,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    output logic              freeze_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [REG_AW-1:0] dest_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              addr_err_out
`ifdef MEM_STAGE_STATS_EN
    ,
    output logic [31:0]       load_cnt_out,
    output logic [31:0]       store_cnt_out,
    output logic [31:0]       stall_cnt_out
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] BASE_W  = DATA_W'(BASE_ADDR);
    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);
    localparam logic [3:0] WAIT_RELOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wb_en_q, wb_en_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] alu_res_q, alu_res_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_op;
    logic              in_range;
    logic              complete;
    logic              freeze;
    logic              mem_we;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] word_off;
    logic [IDX_W-1:0]  idx;

    // Addresses below the base wrap to huge offsets; the explicit >= check rejects them.
    always_comb begin
        mem_op   = mem_r_en_in | mem_w_en_in;
        offset   = alu_res_in - BASE_W;
        word_off = offset >> 2;
        idx      = word_off[IDX_W-1:0];
        in_range = (alu_res_in >= BASE_W) && (word_off < DEPTH_W);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        freeze   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        freeze  = 1'b1;
                        cnt_d   = WAIT_RELOAD;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    freeze = 1'b1;
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        dest_d     = dest_q;
        alu_res_d  = alu_res_q;
        mem_data_d = mem_data_q;
        addr_err_d = addr_err_q;
        if (complete) begin
            wb_en_d    = wb_en_in;
            mem_r_en_d = mem_r_en_in;
            dest_d     = dest_in;
            alu_res_d  = alu_res_in;
            // Read-before-write: a dual-flag access returns the old word.
            mem_data_d = (mem_r_en_in && in_range) ? mem_q[idx] : '0;
            addr_err_d = !in_range;
        end else if (freeze) begin
            wb_en_d    = 1'b0;
            mem_r_en_d = 1'b0;
            addr_err_d = 1'b0;
        end else begin
            wb_en_d    = wb_en_in;
            mem_r_en_d = mem_r_en_in;
            dest_d     = dest_in;
            alu_res_d  = alu_res_in;
            mem_data_d = '0;
            addr_err_d = 1'b0;
        end
    end

    assign mem_we = complete && mem_w_en_in && in_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            dest_q     <= '0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            dest_q     <= dest_d;
            alu_res_q  <= alu_res_d;
            mem_data_q <= mem_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= val_rm_in;
        end
    end

    assign freeze_out   = freeze;
    assign wb_en_out    = wb_en_q;
    assign mem_r_en_out = mem_r_en_q;
    assign dest_out     = dest_q;
    assign alu_res_out  = alu_res_q;
    assign mem_data_out = mem_data_q;
    assign addr_err_out = addr_err_q;

`ifdef MEM_STAGE_STATS_EN
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (complete && mem_r_en_in) load_cnt_d  = load_cnt_q + 32'd1;
        if (complete && mem_w_en_in) store_cnt_d = store_cnt_q + 32'd1;
        if (freeze)                  stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt_q  <= 32'd0;
            store_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign load_cnt_out  = load_cnt_q;
    assign store_cnt_out = store_cnt_q;
    assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: two instances (no wait states, 3 wait states) against a transaction model.
module tb_mem_stage_pipe;

    localparam int DEPTH = 16;
    localparam int BASE  = 1024;

    logic clk;
    logic rst;

    logic        wb_i   [2];
    logic        rd_i   [2];
    logic        wr_i   [2];
    logic [3:0]  dest_i [2];
    logic [31:0] alu_i  [2];
    logic [31:0] val_i  [2];
    logic        frz_o  [2];
    logic        wb_o   [2];
    logic        rd_o   [2];
    logic [3:0]  dest_o [2];
    logic [31:0] alu_o  [2];
    logic [31:0] data_o [2];
    logic        err_o  [2];
`ifdef MEM_STAGE_STATS_EN
    logic [31:0] ld_cnt_o [2];
    logic [31:0] st_cnt_o [2];
    logic [31:0] sl_cnt_o [2];
    int          exp_ld [2];
    int          exp_st [2];
    int          exp_sl [2];
`endif

    int          vectors;
    int          miscompares;
    logic [31:0] model_mem [2][DEPTH];
    int          wait_of [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_stage_pipe #(
            .DATA_W(32), .REG_AW(4), .DEPTH(DEPTH), .BASE_ADDR(BASE),
            .WAIT_CYCLES(g * 3)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .wb_en_in     (wb_i[g]),
            .mem_r_en_in  (rd_i[g]),
            .mem_w_en_in  (wr_i[g]),
            .dest_in      (dest_i[g]),
            .alu_res_in   (alu_i[g]),
            .val_rm_in    (val_i[g]),
            .freeze_out   (frz_o[g]),
            .wb_en_out    (wb_o[g]),
            .mem_r_en_out (rd_o[g]),
            .dest_out     (dest_o[g]),
            .alu_res_out  (alu_o[g]),
            .mem_data_out (data_o[g]),
            .addr_err_out (err_o[g])
`ifdef MEM_STAGE_STATS_EN
            ,
            .load_cnt_out (ld_cnt_o[g]),
            .store_cnt_out(st_cnt_o[g]),
            .stall_cnt_out(sl_cnt_o[g])
`endif
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs(input int k);
        wb_i[k]   = 1'b0;
        rd_i[k]   = 1'b0;
        wr_i[k]   = 1'b0;
        dest_i[k] = 4'd0;
        alu_i[k]  = 32'd0;
        val_i[k]  = 32'd0;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) model_mem[k][i] = 32'd0;
`ifdef MEM_STAGE_STATS_EN
            exp_ld[k] = 0;
            exp_st[k] = 0;
            exp_sl[k] = 0;
`endif
        end
    endtask

    task automatic chk_all_zero(input int k);
        chk("rst_wb_en", 64'(wb_o[k]), 64'd0);
        chk("rst_mem_r_en", 64'(rd_o[k]), 64'd0);
        chk("rst_dest", 64'(dest_o[k]), 64'd0);
        chk("rst_alu_res", 64'(alu_o[k]), 64'd0);
        chk("rst_mem_data", 64'(data_o[k]), 64'd0);
        chk("rst_addr_err", 64'(err_o[k]), 64'd0);
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows completion.
    task automatic do_op(input int k, input logic wb, input logic rd, input logic wr,
                         input logic [3:0] dest, input logic [31:0] addr, input logic [31:0] data);
        int          n;
        int          exp_stall;
        logic        inr;
        longint      off;
        int          ix;
        logic [31:0] exp_data;
        idle_inputs(1 - k);
        wb_i[k]   = wb;
        rd_i[k]   = rd;
        wr_i[k]   = wr;
        dest_i[k] = dest;
        alu_i[k]  = addr;
        val_i[k]  = data;
        exp_stall = (rd || wr) ? wait_of[k] : 0;
        #1;
        n = 0;
        while (frz_o[k] && n < 40) begin
            @(negedge clk);
            #1;
            n++;
            chk("stall_wb_en", 64'(wb_o[k]), 64'd0);
            chk("stall_mem_r_en", 64'(rd_o[k]), 64'd0);
        end
        chk("stall_len", 64'(n), 64'(exp_stall));
        @(negedge clk);
        off = longint'(addr) - longint'(BASE);
        inr = (off >= 0) && ((off / 4) < DEPTH);
        ix  = inr ? int'(off / 4) : 0;
        exp_data = (rd && inr) ? model_mem[k][ix] : 32'd0;
        chk("wb_en", 64'(wb_o[k]), 64'(wb));
        chk("mem_r_en", 64'(rd_o[k]), 64'(rd));
        chk("dest", 64'(dest_o[k]), 64'(dest));
        chk("alu_res", 64'(alu_o[k]), 64'(addr));
        chk("mem_data", 64'(data_o[k]), 64'(exp_data));
        chk("addr_err", 64'(err_o[k]), 64'((rd || wr) ? !inr : 1'b0));
        if (wr && inr) model_mem[k][ix] = data;
`ifdef MEM_STAGE_STATS_EN
        if (rd) exp_ld[k]++;
        if (wr) exp_st[k]++;
        exp_sl[k] += exp_stall;
`endif
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1, 2: rand_addr = 32'(BASE) + 32'($urandom_range(0, 4 * DEPTH - 1));
            3:       rand_addr = 32'(BASE) - 32'($urandom_range(1, 64));
            4:       rand_addr = 32'(BASE + 4 * DEPTH) + 32'($urandom_range(0, 64));
            default: rand_addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        wait_of[0]  = 0;
        wait_of[1]  = 3;
        idle_inputs(0);
        idle_inputs(1);
        clear_model();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk_all_zero(k);
            chk("rst_freeze", 64'(frz_o[k]), 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // No wait states: store then load, data one cycle after the load.
        do_op(0, 1'b0, 1'b0, 1'b1, 4'd0, 32'd1028, 32'hDEAD_BEEF);
        do_op(0, 1'b1, 1'b1, 1'b0, 4'd3, 32'd1028, 32'h0);

        // Three wait states: store then load of word 0.
        do_op(1, 1'b0, 1'b0, 1'b1, 4'd0, 32'd1024, 32'h1234_5678);
        do_op(1, 1'b1, 1'b1, 1'b0, 4'd5, 32'd1024, 32'h0);

        // Out-of-range stores and loads, then a non-memory op.
        for (int k = 0; k < 2; k++) begin
            do_op(k, 1'b0, 1'b0, 1'b1, 4'd1, 32'd1020, 32'hA5A5_A5A5);
            do_op(k, 1'b0, 1'b0, 1'b1, 4'd1, 32'(BASE + 4 * DEPTH), 32'h5A5A_5A5A);
            do_op(k, 1'b1, 1'b1, 1'b0, 4'd2, 32'd1020, 32'h0);
            do_op(k, 1'b1, 1'b1, 1'b0, 4'd2, 32'(BASE + 4 * DEPTH), 32'h0);
            do_op(k, 1'b1, 1'b1, 1'b0, 4'd2, 32'(BASE + 4 * DEPTH - 4), 32'h0);
            do_op(k, 1'b1, 1'b0, 1'b0, 4'd7, 32'h55, 32'h0);
            // Dual-flag access returns the word before the write.
            do_op(k, 1'b1, 1'b1, 1'b1, 4'd9, 32'd1028, 32'hCAFE_F00D);
            do_op(k, 1'b1, 1'b1, 1'b0, 4'd9, 32'd1029, 32'h0);
        end

        // Randomized traffic on both instances.
        for (int t = 0; t < 120; t++) begin
            int k;
            int kind;
            k    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 3));
            do_op(k, 1'($urandom), (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                  4'($urandom), rand_addr(), $urandom);
        end

`ifdef MEM_STAGE_STATS_EN
        for (int k = 0; k < 2; k++) begin
            chk("load_cnt", 64'(ld_cnt_o[k]), 64'(exp_ld[k]));
            chk("store_cnt", 64'(st_cnt_o[k]), 64'(exp_st[k]));
            chk("stall_cnt", 64'(sl_cnt_o[k]), 64'(exp_sl[k]));
        end
`endif

        // Reset in the middle of a wait-state store: the store must never commit.
        idle_inputs(0);
        wr_i[1]  = 1'b1;
        alu_i[1] = 32'd1032;
        val_i[1] = 32'h7777_7777;
        @(negedge clk);
        #1;
        chk("busy_before_rst", 64'(frz_o[1]), 64'd1);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) chk_all_zero(k);
        idle_inputs(1);
        #1;
        chk("rst_freeze_after", 64'(frz_o[1]), 64'd0);
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op(1, 1'b1, 1'b1, 1'b0, 4'd4, 32'd1032, 32'h0);
        do_op(0, 1'b1, 1'b1, 1'b0, 4'd4, 32'd1028, 32'h0);
`ifdef MEM_STAGE_STATS_EN
        do_op(1, 1'b1, 1'b1, 1'b0, 4'd4, 32'd1024, 32'h0);
        do_op(1, 1'b0, 1'b0, 1'b1, 4'd4, 32'd1024, 32'h1);
        chk("load_cnt_after_rst", 64'(ld_cnt_o[1]), 64'(exp_ld[1]));
        chk("store_cnt_after_rst", 64'(st_cnt_o[1]), 64'(exp_st[1]));
        chk("stall_cnt_after_rst", 64'(sl_cnt_o[1]), 64'(exp_sl[1]));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Parametrised memory stage of the pipelined processor: local data memory, wait-state access FSM and MEM/WB pipeline register.
- Sits between the EX/MEM register and the write-back stage.
- Supports configurable word width, memory depth, base address and a fixed multi-cycle access latency.
- Raises `freeze_out` to stall upstream stages while an access is in progress.

Parameters:
- DATA_W, 32, word width of ALU result, store data and memory words.
- REG_AW, 4, destination register index width.
- DEPTH, 64, number of memory words (power of two, ≥2).
- BASE_ADDR, 1024, byte address mapped to word 0.
- WAIT_CYCLES, 0, stall cycles per load/store (0–15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wb_en_in  in  1  write-back enable of the incoming instruction.
- mem_r_en_in  in  1  load request.
- mem_w_en_in  in  1  store request.
- dest_in  in  REG_AW  destination register.
- alu_res_in  in  DATA_W  byte address for loads/stores; result otherwise.
- val_rm_in  in  DATA_W  store data.
- freeze_out  out  1  combinational stall to IF/ID/EX and the pipeline registers.
- wb_en_out  out  1  registered write-back enable.
- mem_r_en_out  out  1  registered load flag.
- dest_out  out  REG_AW  registered destination.
- alu_res_out  out  DATA_W  registered ALU result.
- mem_data_out  out  DATA_W  registered load data.
- addr_err_out  out  1  registered: last completed access was out of range.

Behaviour:
- **Reset (rst=0):**
  - All registered outputs are 0.
  - FSM goes to IDLE and the counter to 0.
  - Every memory word is cleared to 0.
  - An access in progress is aborted; a pending store never commits.
- **Address map:**
  - `idx = (alu_res_in - BASE_ADDR) >> 2`; bits [1:0] are ignored.
  - In range iff `alu_res_in >= BASE_ADDR` and `idx < DEPTH`.
- **FSM states:** IDLE, BUSY. `mem_op = mem_r_en_in | mem_w_en_in`.
- **IDLE, no mem_op:**
  - `freeze_out = 0`.
  - On the edge, the register captures the inputs and `mem_data_out = 0`.
- **IDLE, mem_op, WAIT_CYCLES = 0:**
  - `freeze_out = 0`.
  - The access completes on this edge.
- **IDLE, mem_op, WAIT_CYCLES > 0:**
  - `freeze_out = 1`; the counter loads `WAIT_CYCLES-1` and the FSM goes to BUSY.
  - The register loads a bubble: `wb_en_out = 0`, `mem_r_en_out = 0`, `addr_err_out = 0`; other fields hold.
- **BUSY, counter ≠ 0:** `freeze_out = 1`, counter decrements, register loads a bubble.
- **BUSY, counter = 0:** `freeze_out = 0`, the access completes on this edge and the FSM goes to IDLE.
- **Stall length:** each load/store stalls for exactly WAIT_CYCLES cycles; back-to-back memory ops each pay the full latency.
- **Access completion (single edge):**
  - Store: `mem[idx] <= val_rm_in`, only if in range; the store is performed exactly once.
  - Load: `mem_data_out <= mem[idx]` if in range, else 0.
  - The register captures `wb_en_in`, `mem_r_en_in`, `dest_in`, `alu_res_in`.
  - `addr_err_out <= !in_range`.
- **Load and store both set:**
  - The store is performed.
  - `mem_data_out` returns the pre-write word (read-before-write).
- **Input stability:** inputs are held stable by upstream while `freeze_out = 1`. The block samples them only at completion.

Optional Feature:
- Macro: MEM_STAGE_STATS_EN.
- **Defined:** adds outputs `load_cnt_out`, `store_cnt_out`, `stall_cnt_out`, each 32-bit.
  - Load/store counters increment on each completed access; a dual-flag access counts as both.
  - The stall counter increments on every cycle with `freeze_out = 1`.
  - All counters wrap at 2^32 and are cleared by rst.
- **Undefined:** the ports and logic are absent; all other behaviour is identical.

Test Plan:
- **Reset with WAIT_CYCLES = 3:** assert rst=0 mid-BUSY → all outputs 0, `freeze_out = 0` next cycle, and a subsequent load of that address returns 0.
- **WAIT_CYCLES = 0:** store 0xDEADBEEF at 1028, then load 1028 → `freeze_out` never 1; `mem_data_out = 0xDEADBEEF` and `mem_r_en_out = 1` one cycle after the load is presented.
- **WAIT_CYCLES = 3:** hold a load of 1024 → `freeze_out` high exactly 3 cycles, `wb_en_out = 0` during the stall, then data valid on the next edge; the store before it is committed exactly once.
- **Out-of-range address:** store at 1020 and at 1024+4·DEPTH → memory unchanged, `addr_err_out = 1`; a load from the same addresses gives `mem_data_out = 0`.
- **Non-memory op:** `alu_res_in = 0x55`, `dest = 7`, `wb_en = 1` → registered next edge, no stall, `mem_data_out = 0`.
- **MEM_STAGE_STATS_EN, WAIT_CYCLES = 2:** 2 loads and 1 store → `load_cnt_out = 2`, `store_cnt_out = 1`, `stall_cnt_out = 6`.
